// File: rtl/bsg_fma_aux_pkg.sv
// Shared types and helpers for the aux cross-term arbiter slice.
package bsg_fma_aux_pkg;

  localparam int unsigned bsg_fma_aux_e_lp = 8;

  // One lane's operand bundle at the default half width
  typedef struct packed {
    logic [bsg_fma_aux_e_lp-1:0] a_l;
    logic [bsg_fma_aux_e_lp-1:0] a_h;
    logic [bsg_fma_aux_e_lp-1:0] b_l;
    logic [bsg_fma_aux_e_lp-1:0] b_h;
  } bsg_fma_aux_req_s;

  function automatic int tag_width(input int n);
    return (n <= 32'sd1) ? 32'sd1 : $clog2(n);
  endfunction

endpackage

// File: rtl/bsg_fma_aux_adder.sv
// Aux cross-term adder: (a_l*b_h + a_h*b_l) mod 2^e_p, unsigned, combinational.
module bsg_fma_aux_adder #(
  parameter int e_p = 8
) (
  input  logic [e_p-1:0] a_l_i,
  input  logic [e_p-1:0] a_h_i,
  input  logic [e_p-1:0] b_l_i,
  input  logic [e_p-1:0] b_h_i,
  output logic [e_p-1:0] mod_o
);

  // Everything is evaluated at e_p bits, so carries past the top bit are dropped.
  assign mod_o = (a_l_i * b_h_i) + (a_h_i * b_l_i);

endmodule

// File: rtl/bsg_fma_aux_rr_arb.sv
// Round-robin arbiter: pointer register, wrapping priority scan, one-hot grant.
module bsg_fma_aux_rr_arb
  import bsg_fma_aux_pkg::*;
#(
  parameter  int num_req_p    = 4,
  localparam int tag_width_lp = tag_width(num_req_p)
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  input  logic                    en_i,
  input  logic [num_req_p-1:0]    v_i,
  output logic [num_req_p-1:0]    grant_o,
  output logic [tag_width_lp-1:0] tag_o,
  output logic                    v_o
);

  logic [tag_width_lp-1:0] ptr_s;

  // Scan upward from the pointer with wrap; the first valid lane wins
  always_comb begin
    int idx;
    idx     = 0;
    grant_o = '0;
    tag_o   = '0;
    v_o     = 1'b0;
    if (en_i) begin
      for (int i = 0; i < num_req_p; i++) begin
        idx = (int'(ptr_s) + i) % num_req_p;
        if (!v_o && v_i[idx]) begin
          grant_o[idx] = 1'b1;
          tag_o        = tag_width_lp'(idx);
          v_o          = 1'b1;
        end else begin
          v_o = v_o;
        end
      end
    end else begin
      v_o = 1'b0;
    end
  end

  if (num_req_p == 1) begin : g_single
    assign ptr_s = '0;
  end else begin : g_multi
    logic [tag_width_lp-1:0] ptr_r;

    // Advance to the lane after the winner; hold when nothing is granted
    always_ff @(posedge clk_i) begin
      if (reset_i) begin
        ptr_r <= '0;
      end else if (v_o) begin
        ptr_r <= (tag_o == tag_width_lp'(num_req_p - 1)) ? '0 : tag_o + tag_width_lp'(1);
      end else begin
        ptr_r <= ptr_r;
      end
    end

    assign ptr_s = ptr_r;
  end

endmodule

// File: rtl/bsg_fma_aux_arbiter.sv
// Shares one aux cross-term adder among num_req_p lanes with a registered, tagged output.
// Optional stall counter enabled by BSG_FMA_AUX_ARB_PERF_EN.
module bsg_fma_aux_arbiter
  import bsg_fma_aux_pkg::*;
#(
  parameter  int e_p          = 8,
  parameter  int num_req_p    = 4,
  localparam int tag_width_lp = tag_width(num_req_p)
) (
  input  logic                       clk_i,
  input  logic                       reset_i,
  input  logic [num_req_p-1:0]       v_i,
  input  logic [num_req_p*e_p-1:0]   a_l_i,
  input  logic [num_req_p*e_p-1:0]   a_h_i,
  input  logic [num_req_p*e_p-1:0]   b_l_i,
  input  logic [num_req_p*e_p-1:0]   b_h_i,
  output logic [num_req_p-1:0]       yumi_o,
  output logic                       v_o,
  output logic [e_p-1:0]             mod_o,
  output logic [tag_width_lp-1:0]    tag_o,
  input  logic                       ready_i
`ifdef BSG_FMA_AUX_ARB_PERF_EN
  ,
  output logic [31:0]                stall_cnt_o
`endif
);

  logic                    slot_free_s;
  logic                    grant_v_s;
  logic [tag_width_lp-1:0] grant_tag_s;
  logic [e_p-1:0]          sel_a_l_s, sel_a_h_s, sel_b_l_s, sel_b_h_s;
  logic [e_p-1:0]          sum_s;
  logic                    v_r;
  logic [e_p-1:0]          mod_r;
  logic [tag_width_lp-1:0] tag_r;

  assign slot_free_s = ~v_r | ready_i;

  // Reset gates the enable, so grants drop combinationally while reset is high
  bsg_fma_aux_rr_arb #(.num_req_p(num_req_p)) rr_arb (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .en_i    (slot_free_s & ~reset_i),
    .v_i     (v_i),
    .grant_o (yumi_o),
    .tag_o   (grant_tag_s),
    .v_o     (grant_v_s)
  );

  // One-hot AND-OR mux of the granted lane's operands
  always_comb begin
    sel_a_l_s = '0;
    sel_a_h_s = '0;
    sel_b_l_s = '0;
    sel_b_h_s = '0;
    for (int i = 0; i < num_req_p; i++) begin
      sel_a_l_s = sel_a_l_s | (a_l_i[i*e_p +: e_p] & {e_p{yumi_o[i]}});
      sel_a_h_s = sel_a_h_s | (a_h_i[i*e_p +: e_p] & {e_p{yumi_o[i]}});
      sel_b_l_s = sel_b_l_s | (b_l_i[i*e_p +: e_p] & {e_p{yumi_o[i]}});
      sel_b_h_s = sel_b_h_s | (b_h_i[i*e_p +: e_p] & {e_p{yumi_o[i]}});
    end
  end

  bsg_fma_aux_adder #(.e_p(e_p)) adder (
    .a_l_i (sel_a_l_s),
    .a_h_i (sel_a_h_s),
    .b_l_i (sel_b_l_s),
    .b_h_i (sel_b_h_s),
    .mod_o (sum_s)
  );

  // Output stage: a new grant overwrites (drain and fill in one cycle), a drain alone clears valid
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      v_r   <= 1'b0;
      mod_r <= '0;
      tag_r <= '0;
    end else if (grant_v_s) begin
      v_r   <= 1'b1;
      mod_r <= sum_s;
      tag_r <= grant_tag_s;
    end else if (ready_i) begin
      v_r   <= 1'b0;
    end else begin
      v_r   <= v_r;
    end
  end

  assign v_o   = v_r;
  assign mod_o = mod_r;
  assign tag_o = tag_r;

`ifdef BSG_FMA_AUX_ARB_PERF_EN
  logic [31:0] stall_cnt_r;

  // Count cycles where some lane is waiting on a full, stalled output slot
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      stall_cnt_r <= 32'd0;
    end else if ((|v_i) && !slot_free_s && (stall_cnt_r != 32'hFFFF_FFFF)) begin
      stall_cnt_r <= stall_cnt_r + 32'd1;
    end else begin
      stall_cnt_r <= stall_cnt_r;
    end
  end

  assign stall_cnt_o = stall_cnt_r;
`endif

endmodule

// File: tb/tb_bsg_fma_aux_arbiter.sv
// Scoreboard bench for bsg_fma_aux_arbiter (e_p=8, num_req_p=4).
module tb_bsg_fma_aux_arbiter;

  localparam int n_lp = 4;
`ifdef BSG_FMA_AUX_ARB_PERF_EN
  localparam int bp_n_lp = 5;
`else
  localparam int bp_n_lp = 3;
`endif

  typedef struct {
    logic [7:0] m;
    logic [1:0] t;
  } res_t;

  logic             clk;
  logic             reset_i;
  logic [n_lp-1:0]  v_i;
  logic [n_lp*8-1:0] a_l_i, a_h_i, b_l_i, b_h_i;
  logic [n_lp-1:0]  yumi_o;
  logic             v_o;
  logic [7:0]       mod_o;
  logic [1:0]       tag_o;
  logic             ready_i;
`ifdef BSG_FMA_AUX_ARB_PERF_EN
  logic [31:0]      stall_cnt_o;
`endif

  int         n_cmp;
  int         n_bad;
  int         exp_ptr;
  logic       exp_v;
  logic       pend;
  logic       refill;
  logic [3:0] last_grant;
  res_t       sb[$];

  bsg_fma_aux_arbiter #(.e_p(8), .num_req_p(n_lp)) dut (
    .clk_i   (clk),
    .reset_i (reset_i),
    .v_i     (v_i),
    .a_l_i   (a_l_i),
    .a_h_i   (a_h_i),
    .b_l_i   (b_l_i),
    .b_h_i   (b_h_i),
    .yumi_o  (yumi_o),
    .v_o     (v_o),
    .mod_o   (mod_o),
    .tag_o   (tag_o),
    .ready_i (ready_i)
`ifdef BSG_FMA_AUX_ARB_PERF_EN
    ,
    .stall_cnt_o (stall_cnt_o)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] calc(input logic [7:0] al, input logic [7:0] ah,
                                      input logic [7:0] bl, input logic [7:0] bh);
    logic [15:0] p;
    p = 16'(al) * 16'(bh) + 16'(ah) * 16'(bl);
    return p[7:0];
  endfunction

  task automatic set_lane(input int k, input logic [7:0] al, input logic [7:0] ah,
                          input logic [7:0] bl, input logic [7:0] bh);
    a_l_i[k*8 +: 8] = al;
    a_h_i[k*8 +: 8] = ah;
    b_l_i[k*8 +: 8] = bl;
    b_h_i[k*8 +: 8] = bh;
    v_i[k]          = 1'b1;
  endtask

  // One clock: check v_o, pop/compare last cycle's result, check and record the grant
  task automatic cycle();
    logic [3:0] g;
    res_t       r;
    int         k;
    int         idx;
    k = -1;
    g = 4'b0000;
    @(negedge clk);
    n_cmp++;
    if (v_o !== exp_v) begin
      n_bad++;
      $display("FAIL v_o: got %b expected %b", v_o, exp_v);
    end
    if (pend) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL scoreboard: nothing expected but a result is due");
      end else begin
        r = sb.pop_front();
        n_cmp++;
        if (mod_o !== r.m || tag_o !== r.t) begin
          n_bad++;
          $display("FAIL result: got mod=%h tag=%0d expected mod=%h tag=%0d", mod_o, tag_o, r.m, r.t);
        end
      end
    end
    if (!reset_i && (!exp_v || ready_i)) begin
      for (int o = 0; o < n_lp; o++) begin
        idx = (exp_ptr + o) % n_lp;
        if (k < 0 && v_i[idx]) k = idx;
      end
    end
    if (k >= 0) g[k] = 1'b1;
    n_cmp++;
    if (yumi_o !== g) begin
      n_bad++;
      $display("FAIL yumi_o: got %b expected %b", yumi_o, g);
    end
    last_grant = g;
    if (k >= 0) begin
      r.m = calc(a_l_i[k*8 +: 8], a_h_i[k*8 +: 8], b_l_i[k*8 +: 8], b_h_i[k*8 +: 8]);
      r.t = 2'(k);
      sb.push_back(r);
    end
    @(posedge clk);
    if (reset_i) begin
      exp_v   = 1'b0;
      exp_ptr = 0;
      pend    = 1'b0;
      sb.delete();
    end else begin
      pend = (k >= 0);
      if (k >= 0) begin
        exp_v   = 1'b1;
        exp_ptr = (k + 1) % n_lp;
      end else if (ready_i) begin
        exp_v = 1'b0;
      end
    end
    #1;
    if (k >= 0) begin
      if (refill) set_lane(k, 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
      else v_i[k] = 1'b0;
    end
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while ((v_i != 4'b0000 || pend || exp_v) && guard < 20) begin
      cycle();
      guard++;
    end
    if (guard >= 20) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: lanes still pending after %0d cycles", guard);
    end
  endtask

  task automatic test_reset();
    reset_i = 1'b1;
    cycle();
    set_lane(1, 8'h01, 8'h02, 8'h03, 8'h04);
    #1;
    n_cmp++;
    if (yumi_o !== 4'b0000) begin
      n_bad++;
      $display("FAIL reset_yumi: got %b expected 0000", yumi_o);
    end
    cycle();
    n_cmp++;
    if (v_o !== 1'b0 || mod_o !== 8'h00 || tag_o !== 2'd0) begin
      n_bad++;
      $display("FAIL reset_out: got v=%b mod=%h tag=%0d expected 0/00/0", v_o, mod_o, tag_o);
    end
    reset_i = 1'b0;
    drain();
  endtask

  task automatic test_single();
    set_lane(2, 8'd3, 8'd5, 8'd2, 8'd7);
    #1;
    n_cmp++;
    if (yumi_o !== 4'b0100) begin
      n_bad++;
      $display("FAIL single_yumi: got %b expected 0100", yumi_o);
    end
    cycle();
    cycle();
    n_cmp++;
    if (mod_o !== 8'h1F || tag_o !== 2'd2) begin
      n_bad++;
      $display("FAIL single_result: got mod=%h tag=%0d expected 1f/2", mod_o, tag_o);
    end
  endtask

  task automatic test_wrap();
    set_lane(0, 8'hFF, 8'h10, 8'h10, 8'hFF);
    cycle();
    cycle();
    n_cmp++;
    if (mod_o !== 8'h01 || tag_o !== 2'd0) begin
      n_bad++;
      $display("FAIL wrap_result: got mod=%h tag=%0d expected 01/0", mod_o, tag_o);
    end
  endtask

  task automatic test_round_robin();
    logic [3:0] exp_g;
    set_lane(3, 8'h11, 8'h22, 8'h33, 8'h44);
    drain();
    refill = 1'b1;
    for (int k = 0; k < n_lp; k++)
      set_lane(k, 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
    for (int i = 0; i < 8; i++) begin
      cycle();
      exp_g = 4'b0001 << (i % n_lp);
      n_cmp++;
      if (last_grant !== exp_g || v_o !== 1'b1) begin
        n_bad++;
        $display("FAIL rr_order: step %0d got grant=%b v=%b expected %b/1", i, last_grant, v_o, exp_g);
      end
    end
    refill = 1'b0;
    drain();
  endtask

  task automatic test_backpressure();
    logic [7:0] m0;
    m0 = calc(8'h21, 8'h43, 8'h65, 8'h87);
    set_lane(0, 8'h21, 8'h43, 8'h65, 8'h87);
    cycle();
    ready_i = 1'b0;
    set_lane(1, 8'h0A, 8'h0B, 8'h0C, 8'h0D);
    set_lane(3, 8'hF0, 8'h0F, 8'hAA, 8'h55);
    for (int i = 0; i < bp_n_lp; i++) begin
      cycle();
      n_cmp++;
      if (last_grant !== 4'b0000 || v_o !== 1'b1 || mod_o !== m0 || tag_o !== 2'd0) begin
        n_bad++;
        $display("FAIL bp_hold: cycle %0d got grant=%b v=%b mod=%h tag=%0d expected 0000/1/%h/0",
                 i, last_grant, v_o, mod_o, tag_o, m0);
      end
    end
`ifdef BSG_FMA_AUX_ARB_PERF_EN
    n_cmp++;
    if (stall_cnt_o !== 32'd5) begin
      n_bad++;
      $display("FAIL stall_cnt: got %0d expected 5", stall_cnt_o);
    end
`endif
    ready_i = 1'b1;
    #1;
    n_cmp++;
    if (yumi_o !== 4'b0010) begin
      n_bad++;
      $display("FAIL bp_release: got %b expected 0010", yumi_o);
    end
    drain();
  endtask

  task automatic test_pointer();
    set_lane(2, 8'h05, 8'h06, 8'h07, 8'h08);
    cycle();
    set_lane(1, 8'h09, 8'h0A, 8'h0B, 8'h0C);
    cycle();
    n_cmp++;
    if (last_grant !== 4'b0010) begin
      n_bad++;
      $display("FAIL ptr_lane1: got %b expected 0010", last_grant);
    end
    set_lane(1, 8'h13, 8'h14, 8'h15, 8'h16);
    set_lane(2, 8'h17, 8'h18, 8'h19, 8'h1A);
    cycle();
    n_cmp++;
    if (last_grant !== 4'b0100) begin
      n_bad++;
      $display("FAIL ptr_lane2: got %b expected 0100", last_grant);
    end
    drain();
  endtask

  task automatic test_reset_mid();
    set_lane(2, 8'h31, 8'h32, 8'h33, 8'h34);
    cycle();
    reset_i = 1'b1;
    cycle();
    n_cmp++;
    if (v_o !== 1'b0 || tag_o !== 2'd0 || mod_o !== 8'h00) begin
      n_bad++;
      $display("FAIL mid_reset: got v=%b mod=%h tag=%0d expected 0/00/0", v_o, mod_o, tag_o);
    end
    reset_i = 1'b0;
    set_lane(0, 8'h41, 8'h42, 8'h43, 8'h44);
    set_lane(3, 8'h45, 8'h46, 8'h47, 8'h48);
    cycle();
    n_cmp++;
    if (last_grant !== 4'b0001) begin
      n_bad++;
      $display("FAIL ptr_restart: got %b expected 0001", last_grant);
    end
    drain();
  endtask

  initial begin
    n_cmp   = 0;
    n_bad   = 0;
    exp_ptr = 0;
    exp_v   = 1'b0;
    pend    = 1'b0;
    refill  = 1'b0;
    last_grant = 4'b0000;
    reset_i = 1'b1;
    ready_i = 1'b1;
    v_i     = '0;
    a_l_i   = '0;
    a_h_i   = '0;
    b_l_i   = '0;
    b_h_i   = '0;
    test_reset();
    test_single();
    test_wrap();
    test_round_robin();
    test_backpressure();
    test_pointer();
    test_reset_mid();
    n_cmp++;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL leftover: %0d results never produced, expected 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
